// File: rtl/ysyx_24110026_ifu.sv
`timescale 1ns/1ps
// ysyx_24110026_ifu: instruction fetch unit.
// Holds the PC and fetches one word at a time over a valid/ready request and
// valid-only response port. Each word is handed to the decoder with a valid/ready
// handshake, and only one fetch is ever in flight. A redirect from execute moves
// the PC. Any fetch still in flight when the redirect arrives is marked killed,
// and its response is dropped when it returns. A misaligned redirect target or
// an access fault parks the unit in a sticky FAULT state, which only rst clears.
module ysyx_24110026_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // A fetch target is usable only if it is word aligned.
    function automatic logic misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    state_e      state_r;
    state_e      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic        kill_r;
    logic        kill_s;
    logic        req_valid_r;
    logic        out_valid_r;
    logic        out_valid_s;
    logic [31:0] out_pc_r;
    logic [31:0] out_pc_s;
    logic [31:0] out_inst_r;
    logic [31:0] out_inst_s;
    logic        fault_r;
    logic        fault_s;
    logic [31:0] fault_pc_r;
    logic [31:0] fault_pc_s;
    logic [31:0] fetch_count_r;
    logic [31:0] fetch_count_s;

    logic        req_fire_s;
    logic        consume_s;
    logic        redirect_bad_s;

    assign req_fire_s     = req_valid_r & mem_req_ready;
    assign consume_s      = out_valid_r & out_ready;
    assign redirect_bad_s = misaligned(redirect_pc);

    // Next-state and datapath decisions for the fetch FSM; redirect has top priority.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        kill_s        = kill_r;
        out_valid_s   = out_valid_r;
        out_pc_s      = out_pc_r;
        out_inst_s    = out_inst_r;
        fault_s       = fault_r;
        fault_pc_s    = fault_pc_r;
        fetch_count_s = fetch_count_r;
        case (state_r)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_s = redirect_pc;
                    if (redirect_bad_s) begin
                        state_s    = ST_FAULT;
                        fault_s    = 1'b1;
                        fault_pc_s = redirect_pc;
                        kill_s     = 1'b0;
                    end else if (req_fire_s) begin
                        // The request just accepted targets the old PC: kill it.
                        state_s = ST_WAIT;
                        kill_s  = 1'b1;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else if (req_fire_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_s = redirect_pc;
                    if (redirect_bad_s) begin
                        state_s    = ST_FAULT;
                        fault_s    = 1'b1;
                        fault_pc_s = redirect_pc;
                        kill_s     = 1'b0;
                    end else if (mem_rsp_valid) begin
                        // Response for the old path lands with the redirect: drop it now.
                        state_s = ST_REQ;
                        kill_s  = 1'b0;
                    end else begin
                        state_s = ST_WAIT;
                        kill_s  = 1'b1;
                    end
                end else if (mem_rsp_valid) begin
                    if (kill_r) begin
                        state_s = ST_REQ;
                        kill_s  = 1'b0;
                    end else if (mem_rsp_err) begin
                        state_s    = ST_FAULT;
                        fault_s    = 1'b1;
                        fault_pc_s = pc_r;
                    end else begin
                        state_s     = ST_HOLD;
                        out_valid_s = 1'b1;
                        out_pc_s    = pc_r;
                        out_inst_s  = mem_rsp_data;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                // A decoder handshake always counts, even alongside a redirect.
                if (consume_s) begin
                    fetch_count_s = fetch_count_r + 32'd1;
                end else begin
                    fetch_count_s = fetch_count_r;
                end
                if (redirect_valid) begin
                    pc_s        = redirect_pc;
                    out_valid_s = 1'b0;
                    out_inst_s  = NOP_INST;
                    if (redirect_bad_s) begin
                        state_s    = ST_FAULT;
                        fault_s    = 1'b1;
                        fault_pc_s = redirect_pc;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else if (consume_s) begin
                    pc_s        = pc_r + 32'd4;
                    out_valid_s = 1'b0;
                    out_inst_s  = NOP_INST;
                    state_s     = ST_REQ;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_FAULT: begin
                state_s     = ST_FAULT;
                fault_s     = 1'b1;
                kill_s      = 1'b0;
                out_valid_s = 1'b0;
                out_inst_s  = NOP_INST;
            end
            default: begin
                // Unreachable encoding: park safely rather than fetch garbage.
                state_s     = ST_FAULT;
                fault_s     = 1'b1;
                fault_pc_s  = pc_r;
                kill_s      = 1'b0;
                out_valid_s = 1'b0;
                out_inst_s  = NOP_INST;
            end
        endcase
    end

    // State and output registers; rst returns the unit to the first fetch at RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_REQ;
            pc_r          <= RESET_PC;
            kill_r        <= 1'b0;
            req_valid_r   <= 1'b0;
            out_valid_r   <= 1'b0;
            out_pc_r      <= 32'h0000_0000;
            out_inst_r    <= NOP_INST;
            fault_r       <= 1'b0;
            fault_pc_r    <= 32'h0000_0000;
            fetch_count_r <= 32'h0000_0000;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            kill_r        <= kill_s;
            req_valid_r   <= (state_s == ST_REQ);
            out_valid_r   <= out_valid_s;
            out_pc_r      <= out_pc_s;
            out_inst_r    <= out_inst_s;
            fault_r       <= fault_s;
            fault_pc_r    <= fault_pc_s;
            fetch_count_r <= fetch_count_s;
        end
    end

    assign mem_req_valid = req_valid_r;
    assign mem_req_addr  = pc_r;
    assign out_valid     = out_valid_r;
    assign out_pc        = out_pc_r;
    assign out_inst      = out_inst_r;
    assign fault         = fault_r;
    assign fault_pc      = fault_pc_r;
    assign fetch_count   = fetch_count_r;

endmodule
